// File: rtl/vz_loader.sv
// VZ image loader: parses the ioctl VZ stream and writes its payload into
// Laser310 RAM, then patches the BASIC end pointer or requests autorun.
module vz_loader #(
  parameter logic [7:0]  VZ_INDEX = 8'd1,
  parameter logic [15:0] RAM_LOW  = 16'h7800,
  parameter logic [15:0] PTR_ADDR = 16'h78F9
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dn_download,
  input  logic [7:0]  dn_index,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        cpu_hold,
  output logic        exec_req,
  output logic [15:0] exec_addr,
  output logic [7:0]  file_type,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, HEADER, DATA, POST_LO, POST_HI, DONE, ERROR
  } state_t;

  state_t      state;
  logic        dl_q;
  logic        fall_q;
  logic        hold;
  logic        ok_a;
  logic        ok_b;
  logic [15:0] last_addr;

  logic        rise;
  logic        fall;
  logic        idle_like;
  logic [15:0] daddr;
  logic [15:0] ptr_val;
  logic [7:0]  mag_a;
  logic [7:0]  mag_b;
  logic        na;
  logic        nb;
  logic        type_ok;

  assign rise      = dn_download & ~dl_q & (dn_index == VZ_INDEX);
  assign fall      = ~dn_download & dl_q;
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);
  assign daddr     = exec_addr + (dn_addr - 16'd24);
  assign ptr_val   = last_addr + 16'd1;
  assign type_ok   = (dn_data == 8'hF0) || (dn_data == 8'hF1);

  // Two accepted magics: "VZF0" and "  \0\0"
  always_comb begin
    mag_a = 8'h56;
    mag_b = 8'h20;
    unique case (dn_addr[1:0])
      2'd0: begin mag_a = 8'h56; mag_b = 8'h20; end
      2'd1: begin mag_a = 8'h5A; mag_b = 8'h20; end
      2'd2: begin mag_a = 8'h46; mag_b = 8'h00; end
      2'd3: begin mag_a = 8'h30; mag_b = 8'h00; end
    endcase
  end

  assign na = ok_a & (dn_data == mag_a);
  assign nb = ok_b & (dn_data == mag_b);

  assign cpu_hold = hold;
  assign busy     = hold;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      // Seeding with the live level blocks a false re-arm mid-stream
      dl_q      <= dn_download;
      fall_q    <= 1'b0;
      hold      <= 1'b0;
      ok_a      <= 1'b0;
      ok_b      <= 1'b0;
      last_addr <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      exec_req  <= 1'b0;
      exec_addr <= '0;
      file_type <= '0;
      err       <= 1'b0;
    end else begin
      dl_q     <= dn_download;
      fall_q   <= fall;
      ram_we   <= 1'b0;
      exec_req <= 1'b0;
      if (rise && idle_like) begin
        state     <= HEADER;
        err       <= 1'b0;
        file_type <= '0;
        exec_addr <= '0;
        hold      <= 1'b1;
        ok_a      <= 1'b1;
        ok_b      <= 1'b1;
        fall_q    <= 1'b0;
      end else begin
        unique case (state)
          HEADER: begin
            if (fall_q) begin
              state <= ERROR;
              err   <= 1'b1;
              hold  <= 1'b0;
            end else if (dn_wr) begin
              if (dn_addr < 16'd4) begin
                ok_a <= na;
                ok_b <= nb;
                if (!na && !nb) begin
                  state <= ERROR;
                  err   <= 1'b1;
                  hold  <= 1'b0;
                end
              end else if (dn_addr == 16'd21) begin
                file_type <= dn_data;
                if (!type_ok) begin
                  state <= ERROR;
                  err   <= 1'b1;
                  hold  <= 1'b0;
                end
              end else if (dn_addr == 16'd22) begin
                exec_addr[7:0] <= dn_data;
              end else if (dn_addr == 16'd23) begin
                exec_addr[15:8] <= dn_data;
                last_addr <= {dn_data, exec_addr[7:0]} - 16'd1;
                state     <= DATA;
              end
            end
          end
          DATA: begin
            if (fall_q) begin
              if (file_type == 8'hF0) begin
                state <= POST_LO;
              end else begin
                state    <= DONE;
                exec_req <= 1'b1;
                hold     <= 1'b0;
              end
            end else if (dn_wr && dn_addr >= 16'd24) begin
              last_addr <= daddr;
              if (daddr < RAM_LOW) begin
                err <= 1'b1;
              end else begin
                ram_we   <= 1'b1;
                ram_addr <= daddr;
                ram_din  <= dn_data;
              end
            end
          end
          POST_LO: begin
            ram_we   <= 1'b1;
            ram_addr <= PTR_ADDR;
            ram_din  <= ptr_val[7:0];
            state    <= POST_HI;
          end
          POST_HI: begin
            ram_we   <= 1'b1;
            ram_addr <= PTR_ADDR + 16'd1;
            ram_din  <= ptr_val[15:8];
            state    <= DONE;
            hold     <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vz_loader.sv
// Randomized bench for vz_loader against a file-level reference model.
module tb_vz_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        dn_download = 1'b0;
  logic [7:0]  dn_index = '0;
  logic        dn_wr = 1'b0;
  logic [15:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        cpu_hold;
  logic        exec_req;
  logic [15:0] exec_addr;
  logic [7:0]  file_type;
  logic        busy;
  logic        err;

  vz_loader dut (
    .clk_sys(clk_sys), .reset(reset),
    .dn_download(dn_download), .dn_index(dn_index),
    .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .cpu_hold(cpu_hold), .exec_req(exec_req),
    .exec_addr(exec_addr), .file_type(file_type),
    .busy(busy), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [23:0] wq[$];
  int          exec_n = 0;

  always @(negedge clk_sys) begin
    if (ram_we === 1'b1) wq.push_back({ram_addr, ram_din});
    if (exec_req === 1'b1) exec_n++;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  logic [7:0]  fb[$];
  logic [7:0]  mag_a[4] = '{8'h56, 8'h5A, 8'h46, 8'h30};
  logic [7:0]  mag_b[4] = '{8'h20, 8'h20, 8'h00, 8'h00};

  logic [23:0] exp_w[$];
  int          exp_exec;
  logic        m_err = 1'b0;
  logic [7:0]  m_type = '0;
  logic [15:0] m_ea = '0;

  task automatic build(input bit alt, input logic [7:0] typ,
                       input logic [15:0] start, input int n);
    fb.delete();
    for (int i = 0; i < 4; i++) fb.push_back(alt ? mag_b[i] : mag_a[i]);
    for (int i = 0; i < 17; i++) fb.push_back(8'($urandom_range(32, 126)));
    fb.push_back(typ);
    fb.push_back(start[7:0]);
    fb.push_back(start[15:8]);
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
  endtask

  // Expected effect of downloading fb under index idx
  task automatic model(input logic [7:0] idx);
    bit          bad;
    bit          oka;
    bit          okb;
    int          hdr;
    int          n;
    logic [15:0] a;
    logic [15:0] p;
    exp_w.delete();
    exp_exec = 0;
    if (idx != 8'd1) return;
    m_err  = 1'b0;
    m_type = '0;
    m_ea   = '0;
    bad = 0;
    oka = 1;
    okb = 1;
    hdr = (fb.size() < 24) ? fb.size() : 24;
    for (int i = 0; i < hdr && !bad; i++) begin
      if (i < 4) begin
        oka = oka && (fb[i] == mag_a[i]);
        okb = okb && (fb[i] == mag_b[i]);
        if (!oka && !okb) bad = 1;
      end else if (i == 21) begin
        m_type = fb[i];
        if (fb[i] != 8'hF0 && fb[i] != 8'hF1) bad = 1;
      end else if (i == 22) begin
        m_ea[7:0] = fb[i];
      end else if (i == 23) begin
        m_ea[15:8] = fb[i];
      end
    end
    if (fb.size() < 24) bad = 1;
    if (bad) begin
      m_err = 1'b1;
      return;
    end
    n = fb.size() - 24;
    for (int j = 0; j < n; j++) begin
      a = m_ea + 16'(j);
      if (a < 16'h7800) m_err = 1'b1;
      else exp_w.push_back({a, fb[24 + j]});
    end
    if (m_type == 8'hF0) begin
      p = m_ea + 16'(n);
      exp_w.push_back({16'h78F9, p[7:0]});
      exp_w.push_back({16'h78FA, p[15:8]});
    end else begin
      exp_exec = 1;
    end
  endtask

  task automatic stream(input int from, input int to);
    for (int i = from; i < to; i++) begin
      dn_wr   = 1'b1;
      dn_addr = 16'(i);
      dn_data = fb[i];
      tick();
      dn_wr = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic final_checks(input string nm);
    int k;
    check({nm, "/nwr"}, wq.size(), exp_w.size());
    k = (wq.size() < exp_w.size()) ? wq.size() : exp_w.size();
    for (int i = 0; i < k; i++)
      check($sformatf("%s/wr%0d", nm, i), {8'h0, wq[i]}, {8'h0, exp_w[i]});
    check({nm, "/exec"}, exec_n, exp_exec);
    check({nm, "/err"}, err, m_err);
    check({nm, "/type"}, file_type, m_type);
    check({nm, "/eaddr"}, exec_addr, m_ea);
    check({nm, "/hold"}, cpu_hold, 0);
    check({nm, "/busy"}, busy, 0);
  endtask

  task automatic run_load(input string nm, input logic [7:0] idx);
    model(idx);
    wq.delete();
    exec_n = 0;
    dn_index    = idx;
    dn_download = 1'b1;
    tick();
    check({nm, "/hold0"}, cpu_hold, 32'(idx == 8'd1));
    stream(0, fb.size());
    dn_download = 1'b0;
    repeat (8) tick();
    final_checks(nm);
  endtask

  function automatic logic [31:0] outs_or();
    return {31'b0, ram_we | cpu_hold | exec_req | busy | err |
            (|ram_addr) | (|ram_din) | (|exec_addr) | (|file_type)};
  endfunction

  initial begin
    repeat (3) tick();
    check("reset/outs", outs_or(), 0);
    reset = 1'b0;
    tick();

    build(0, 8'hF0, 16'h7AE9, 0);
    fb.push_back(8'hAA); fb.push_back(8'hBB); fb.push_back(8'hCC);
    run_load("basic", 8'd1);
    check("basic/ptrlo", {8'h0, wq.size() > 3 ? wq[3] : 24'h0},
          {8'h0, 24'h78F9EC});

    build(0, 8'hF1, 16'h8000, 2);
    run_load("binary", 8'd1);

    build(0, 8'hF0, 16'h9000, 4);
    fb[2] = 8'h47;
    run_load("badmagic", 8'd1);

    build(1, 8'hF1, 16'hFFFF, 2);
    run_load("wrap", 8'd1);

    build(0, 8'hF0, 16'h7AE9, 3);
    run_load("otheridx", 8'd0);

    // Reset while data is streaming: only the first five bytes land
    build(0, 8'hF0, 16'h9000, 10);
    wq.delete();
    exec_n = 0;
    exp_w.delete();
    for (int j = 0; j < 5; j++) exp_w.push_back({16'h9000 + 16'(j), fb[24 + j]});
    exp_exec = 0;
    m_err = 1'b0;
    m_type = '0;
    m_ea = '0;
    dn_index = 8'd1;
    dn_download = 1'b1;
    tick();
    stream(0, 29);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("rstmid/outs", outs_or(), 0);
    reset = 1'b0;
    stream(29, fb.size());
    dn_download = 1'b0;
    repeat (8) tick();
    final_checks("rstmid");

    for (int t = 0; t < 40; t++) begin
      logic [15:0] st;
      logic [7:0]  ty;
      logic [7:0]  ix;
      int          sel;
      sel = $urandom_range(0, 3);
      unique case (sel)
        0: st = 16'($urandom_range(16'h7800, 16'hFFFF));
        1: st = 16'hFFF0 + 16'($urandom_range(0, 15));
        2: st = 16'h77F0 + 16'($urandom_range(0, 31));
        default: st = 16'($urandom);
      endcase
      ty = ($urandom_range(0, 7) == 0) ? 8'hF2 :
           (($urandom_range(0, 1) == 0) ? 8'hF0 : 8'hF1);
      build(1'($urandom_range(0, 1)), ty, st, $urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) begin
        int k;
        k = $urandom_range(0, 3);
        fb[k] = fb[k] ^ 8'h01;
      end
      if ($urandom_range(0, 9) == 0) begin
        int l;
        l = $urandom_range(4, 23);
        while (fb.size() > l) void'(fb.pop_back());
      end
      ix = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(2, 255)) : 8'd1;
      run_load($sformatf("rnd%0d", t), ix);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
